// File: rtl/rvx_core_state_ctrl_pkg.sv
// Shared state encodings and widths for the core state controller.
// State codes are fixed 4-bit values visible on current_state_s1.
package rvx_core_state_ctrl_pkg;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      RVX_STATE_RESET        = 4'd0,
      RVX_STATE_OPERATING    = 4'd1,
      RVX_STATE_TRAP_TAKEN   = 4'd2,
      RVX_STATE_TRAP_RETURN  = 4'd3,
      RVX_STATE_WFI_SLEEP    = 4'd4,
      RVX_STATE_DEBUG_HALT   = 4'd5,
      RVX_STATE_DEBUG_RESUME = 4'd6
   } rvx_state_e;

endpackage

// File: rtl/rvx_core_state_ctrl_if.sv
// Event inputs and pipeline-control outputs between the trap/CSR unit,
// the debug module and the core state controller.
interface rvx_core_state_ctrl_if;
   import rvx_core_state_ctrl_pkg::*;

   logic               take_trap_s1;
   logic               mret_s1;
   logic               wfi_s1;
   logic               interrupt_pending;
   logic               debug_halt_req;
   logic               debug_resume_req;
   logic [STATE_W-1:0] current_state_s1;
   logic               flush_pipeline_s1;
   logic               stall_pipeline_s1;
   logic               debug_halted;
   logic               core_sleeping;

   modport master (
      output take_trap_s1, mret_s1, wfi_s1, interrupt_pending,
             debug_halt_req, debug_resume_req,
      input  current_state_s1, flush_pipeline_s1, stall_pipeline_s1,
             debug_halted, core_sleeping
   );

   modport slave (
      input  take_trap_s1, mret_s1, wfi_s1, interrupt_pending,
             debug_halt_req, debug_resume_req,
      output current_state_s1, flush_pipeline_s1, stall_pipeline_s1,
             debug_halted, core_sleeping
   );

endinterface

// File: rtl/rvx_core_state_ctrl_counter.sv
// Down-counter timing the flush dwell of the counted states; saturates at zero.
module rvx_core_state_counter
   import rvx_core_state_ctrl_pkg::*;
#(
   parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= RESET_VALUE;
      end else if (load) begin
         count_q <= load_value;
      end else if (enable && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/rvx_core_state_ctrl.sv
// Core state controller: sequences reset, trap entry/return flushes,
// WFI sleep and debug halt/resume; outputs decode the state register only.
module rvx_core_state_ctrl
   import rvx_core_state_ctrl_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 1,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter bit          WFI_ENABLE   = 1'b1,
   parameter bit          DEBUG_ENABLE = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clock_enable,
   rvx_core_state_ctrl_if.slave  ctrl
);

   if (RESET_CYCLES < 1 || RESET_CYCLES > 15) begin : g_bad_reset_cycles
      $error("RESET_CYCLES must be in 1..15");
   end
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("FLUSH_CYCLES must be in 1..15");
   end

   localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   rvx_state_e       state_q, state_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_value, cnt_count;
   logic             unused_cnt;

   assign unused_cnt = ^cnt_count;

   // Counter loads are gated with clock_enable so state and count freeze together.
   rvx_core_state_counter #(
      .RESET_VALUE (RESET_LOAD)
   ) u_counter (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (cnt_load & clock_enable),
      .load_value (cnt_load_value),
      .enable     (cnt_dec & clock_enable),
      .count      (cnt_count),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RVX_STATE_RESET;
      end else if (clock_enable) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_load       = 1'b0;
      cnt_load_value = FLUSH_LOAD;
      cnt_dec        = 1'b0;
      case (state_q)
         RVX_STATE_RESET, RVX_STATE_TRAP_TAKEN,
         RVX_STATE_TRAP_RETURN, RVX_STATE_DEBUG_RESUME: begin
            // A halt arriving here waits: the flush must finish first.
            if (cnt_zero) state_d = RVX_STATE_OPERATING;
            else          cnt_dec = 1'b1;
         end
         RVX_STATE_OPERATING: begin
            if (DEBUG_ENABLE && ctrl.debug_halt_req) begin
               state_d = RVX_STATE_DEBUG_HALT;
            end else if (ctrl.take_trap_s1) begin
               state_d  = RVX_STATE_TRAP_TAKEN;
               cnt_load = 1'b1;
            end else if (ctrl.mret_s1) begin
               state_d  = RVX_STATE_TRAP_RETURN;
               cnt_load = 1'b1;
            end else if (WFI_ENABLE && ctrl.wfi_s1 && !ctrl.interrupt_pending) begin
               state_d = RVX_STATE_WFI_SLEEP;
            end
         end
         RVX_STATE_WFI_SLEEP: begin
            if (DEBUG_ENABLE && ctrl.debug_halt_req) state_d = RVX_STATE_DEBUG_HALT;
            else if (ctrl.interrupt_pending)          state_d = RVX_STATE_OPERATING;
         end
         RVX_STATE_DEBUG_HALT: begin
            if (ctrl.debug_resume_req) begin
               state_d  = RVX_STATE_DEBUG_RESUME;
               cnt_load = 1'b1;
            end
         end
         default: begin
            state_d        = RVX_STATE_RESET;
            cnt_load       = 1'b1;
            cnt_load_value = RESET_LOAD;
         end
      endcase
   end

   assign ctrl.current_state_s1  = state_q;
   assign ctrl.flush_pipeline_s1 = state_q inside {RVX_STATE_RESET, RVX_STATE_TRAP_TAKEN,
                                                   RVX_STATE_TRAP_RETURN, RVX_STATE_DEBUG_RESUME};
   assign ctrl.stall_pipeline_s1 = state_q inside {RVX_STATE_WFI_SLEEP, RVX_STATE_DEBUG_HALT};
   assign ctrl.debug_halted      = (state_q == RVX_STATE_DEBUG_HALT);
   assign ctrl.core_sleeping     = (state_q == RVX_STATE_WFI_SLEEP);

endmodule

// File: tb/tb_rvx_core_state_ctrl.sv
// Self-checking bench for rvx_core_state_ctrl: directed table, corner sequences,
// and randomized traffic against a dwell-time reference model.
module tb_rvx_core_state_ctrl;

   localparam int RA = 3, FA = 2, RB = 1, FB = 1;
   localparam logic [3:0] S_RST = 4'd0, S_OP = 4'd1, S_TT = 4'd2, S_TR = 4'd3,
                          S_WFI = 4'd4, S_DH = 4'd5, S_DR = 4'd6;

   typedef struct packed {
      bit ce, trap, mret, wfi, ip, halt, resume;
   } stim_t;

   typedef struct {
      stim_t      in;
      logic [3:0] exp;
   } vec_t;

   logic clock = 1'b0;
   logic rst_a_n, rst_b_n, ce_a, ce_b;
   int   n_checks = 0, n_fail = 0;

   rvx_core_state_ctrl_if if_a ();
   rvx_core_state_ctrl_if if_b ();

   rvx_core_state_ctrl #(
      .RESET_CYCLES (RA), .FLUSH_CYCLES (FA), .WFI_ENABLE (1'b1), .DEBUG_ENABLE (1'b1)
   ) dut_a (
      .clock (clock), .reset_n (rst_a_n), .clock_enable (ce_a), .ctrl (if_a)
   );

   rvx_core_state_ctrl #(
      .RESET_CYCLES (RB), .FLUSH_CYCLES (FB), .WFI_ENABLE (1'b0), .DEBUG_ENABLE (1'b0)
   ) dut_b (
      .clock (clock), .reset_n (rst_b_n), .clock_enable (ce_b), .ctrl (if_b)
   );

   always #5 clock = ~clock;

   logic [7:0] obs_a, obs_b;
   assign obs_a = {if_a.current_state_s1, if_a.flush_pipeline_s1, if_a.stall_pipeline_s1,
                   if_a.debug_halted, if_a.core_sleeping};
   assign obs_b = {if_b.current_state_s1, if_b.flush_pipeline_s1, if_b.stall_pipeline_s1,
                   if_b.debug_halted, if_b.core_sleeping};

   stim_t      cur_a, cur_b;
   logic [3:0] ma, mb;
   int         ra, rb;

   function automatic logic [7:0] exp_outs(input logic [3:0] st);
      logic fl, sl;
      fl = (st == S_RST) || (st == S_TT) || (st == S_TR) || (st == S_DR);
      sl = (st == S_WFI) || (st == S_DH);
      return {st, fl, sl, st == S_DH, st == S_WFI};
   endfunction

   // Reference: rem counts the flush cycles still to be spent in the current state.
   task automatic model_next(input int f, input bit wen, input bit den, input stim_t s,
                             inout logic [3:0] mode, inout int rem);
      if (!s.ce) return;
      case (mode)
         S_RST, S_TT, S_TR, S_DR: begin
            rem = rem - 1;
            if (rem == 0) mode = S_OP;
         end
         S_OP: begin
            if (den && s.halt)                   mode = S_DH;
            else if (s.trap)                     begin mode = S_TT; rem = f; end
            else if (s.mret)                     begin mode = S_TR; rem = f; end
            else if (wen && s.wfi && !s.ip)      mode = S_WFI;
         end
         S_WFI: begin
            if (den && s.halt) mode = S_DH;
            else if (s.ip)     mode = S_OP;
         end
         S_DH: if (s.resume) begin mode = S_DR; rem = f; end
         default: mode = S_RST;
      endcase
   endtask

   task automatic apply(input stim_t a, input stim_t b);
      cur_a = a; cur_b = b;
      ce_a = a.ce; ce_b = b.ce;
      if_a.take_trap_s1 = a.trap; if_a.mret_s1 = a.mret; if_a.wfi_s1 = a.wfi;
      if_a.interrupt_pending = a.ip; if_a.debug_halt_req = a.halt;
      if_a.debug_resume_req = a.resume;
      if_b.take_trap_s1 = b.trap; if_b.mret_s1 = b.mret; if_b.wfi_s1 = b.wfi;
      if_b.interrupt_pending = b.ip; if_b.debug_halt_req = b.halt;
      if_b.debug_resume_req = b.resume;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (!rst_a_n) begin ma = S_RST; ra = RA; end
      else model_next(FA, 1'b1, 1'b1, cur_a, ma, ra);
      if (!rst_b_n) begin mb = S_RST; rb = RB; end
      else model_next(FB, 1'b0, 1'b0, cur_b, mb, rb);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (state,flush,stall,halted,sleeping)",
                  name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] in, input logic [3:0] e);
      vec_t v;
      v.in  = stim_t'(in);
      v.exp = e;
      return v;
   endfunction

   function automatic stim_t rnd(input bit halt);
      stim_t s;
      s.ce     = ($urandom_range(0, 7) != 0);
      s.trap   = ($urandom_range(0, 5) == 0);
      s.mret   = ($urandom_range(0, 5) == 0);
      s.wfi    = ($urandom_range(0, 3) == 0);
      s.ip     = ($urandom_range(0, 3) == 0);
      s.halt   = halt;
      s.resume = ($urandom_range(0, 4) == 0);
      return s;
   endfunction

   vec_t  tbl[$];
   stim_t idle;
   int    n;
   bit    ha, hb;

   initial begin
      idle = stim_t'(7'b1000000);
      //              ce trap mret wfi ip halt resume
      tbl.push_back(mk(7'b1000000, S_RST));
      tbl.push_back(mk(7'b1000000, S_RST));
      tbl.push_back(mk(7'b1000000, S_OP));
      tbl.push_back(mk(7'b1110000, S_TT));
      tbl.push_back(mk(7'b1000000, S_TT));
      tbl.push_back(mk(7'b1000000, S_OP));
      tbl.push_back(mk(7'b1010000, S_TR));
      tbl.push_back(mk(7'b0000000, S_TR));
      tbl.push_back(mk(7'b1000000, S_TR));
      tbl.push_back(mk(7'b1000000, S_OP));
      tbl.push_back(mk(7'b1001100, S_OP));
      tbl.push_back(mk(7'b1001000, S_WFI));
      tbl.push_back(mk(7'b1000000, S_WFI));
      tbl.push_back(mk(7'b1100000, S_WFI));
      tbl.push_back(mk(7'b1000100, S_OP));
      tbl.push_back(mk(7'b1000010, S_DH));
      tbl.push_back(mk(7'b1111010, S_DH));
      tbl.push_back(mk(7'b1000011, S_DR));
      tbl.push_back(mk(7'b1000010, S_DR));
      tbl.push_back(mk(7'b1000010, S_OP));
      tbl.push_back(mk(7'b1000010, S_DH));
      tbl.push_back(mk(7'b1000000, S_DH));
      tbl.push_back(mk(7'b1000001, S_DR));
      tbl.push_back(mk(7'b1000000, S_DR));
      tbl.push_back(mk(7'b1000000, S_OP));
      tbl.push_back(mk(7'b1001000, S_WFI));
      tbl.push_back(mk(7'b1000010, S_DH));
      tbl.push_back(mk(7'b1000001, S_DR));
      tbl.push_back(mk(7'b1000000, S_DR));
      tbl.push_back(mk(7'b1000000, S_OP));
      tbl.push_back(mk(7'b0000010, S_OP));
      tbl.push_back(mk(7'b1000000, S_OP));

      apply(idle, idle);
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_a", obs_a, exp_outs(S_RST));
      check("reset_b", obs_b, exp_outs(S_RST));
      ma = S_RST; ra = RA; mb = S_RST; rb = RB;
      rst_a_n = 1'b1; rst_b_n = 1'b1;

      foreach (tbl[i]) begin
         apply(tbl[i].in, idle);
         tick();
         check($sformatf("vec%0d", i), obs_a, exp_outs(tbl[i].exp));
      end
      check("b_after_reset", obs_b, exp_outs(S_OP));

      // Asynchronous reset in the middle of a trap flush, then reset dwell.
      apply(stim_t'(7'b1100000), idle);
      tick();
      check("trap_enter", obs_a, exp_outs(S_TT));
      apply(idle, idle);
      #3;
      rst_a_n = 1'b0;
      #1;
      check("async_reset", obs_a, exp_outs(S_RST));
      tick();
      rst_a_n = 1'b1;
      check("reset_held", obs_a, exp_outs(S_RST));
      n = 0;
      while (obs_a[7:4] == S_RST && n < 10) begin tick(); n++; end
      check("reset_dwell", 8'(n), 8'(RA));
      check("reset_exit", obs_a, exp_outs(S_OP));

      // clock_enable low inside TRAP_RETURN.
      apply(stim_t'(7'b1010000), idle);
      tick();
      check("mret_enter", obs_a, exp_outs(S_TR));
      apply(stim_t'(7'b0000000), idle);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ce_freeze", obs_a, exp_outs(S_TR));
      end
      apply(idle, idle);
      n = 0;
      while (obs_a[7:4] == S_TR && n < 10) begin tick(); n++; end
      check("mret_dwell", 8'(n), 8'(FA));
      check("mret_exit", obs_a, exp_outs(S_OP));

      // WFI sleep held for 10 cycles, woken by an interrupt.
      apply(stim_t'(7'b1001000), idle);
      tick();
      check("wfi_enter", obs_a, exp_outs(S_WFI));
      apply(idle, idle);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("wfi_hold", obs_a, exp_outs(S_WFI));
      end
      apply(stim_t'(7'b1000100), idle);
      tick();
      check("wfi_wake", obs_a, exp_outs(S_OP));

      // Halt requested during a trap flush is deferred.
      apply(stim_t'(7'b1100000), idle);
      tick();
      check("halt_tt0", obs_a, exp_outs(S_TT));
      apply(stim_t'(7'b1000010), idle);
      tick();
      check("halt_tt1", obs_a, exp_outs(S_TT));
      tick();
      check("halt_op", obs_a, exp_outs(S_OP));
      tick();
      check("halt_dh", obs_a, exp_outs(S_DH));
      apply(stim_t'(7'b1000001), idle);
      tick();
      check("resume_dr0", obs_a, exp_outs(S_DR));
      apply(idle, idle);
      tick();
      check("resume_dr1", obs_a, exp_outs(S_DR));
      tick();
      check("resume_op", obs_a, exp_outs(S_OP));

      // Features disabled: wfi and halt ignored.
      apply(idle, stim_t'(7'b1001010));
      for (int i = 0; i < 6; i++) begin
         tick();
         check("b_disabled", obs_b, exp_outs(S_OP));
      end
      apply(idle, stim_t'(7'b1101010));
      tick();
      check("b_trap", obs_b, exp_outs(S_TT));
      apply(idle, stim_t'(7'b1001010));
      tick();
      check("b_trap_exit", obs_b, exp_outs(S_OP));

      ha = 1'b0; hb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) ha = !ha;
         if ($urandom_range(0, 9) == 0) hb = !hb;
         apply(rnd(ha), rnd(hb));
         tick();
         check("rand_a", obs_a, exp_outs(ma));
         check("rand_b", obs_b, exp_outs(mb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
